keypad_scanner: RTL

Scans a 4x4 matrix keypad. It drives one row low at a time, lets the lines settle, and samples the four column inputs through a two-flop synchronizer. After a full sweep it publishes a 16-bit raw key map. It sits directly upstream of the keypad debounce/jitter stage, whose 16-bit key-map input it drives. It does no debouncing and no ghost rejection.

---
 rtl/keypad_scanner_if.sv | 10 +
 rtl/keypad_scanner.sv | 87 ++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the published raw key map toward the debounce stage.
interface keypad_scanner_if;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] keys_pressed;
  logic        scan_done;

  modport master (input cols, output rows, output keys_pressed, output scan_done);
  modport slave  (output cols, input rows, input keys_pressed, input scan_done);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: drives one row low per SETTLE_CYCLES, samples synchronized columns,
// publishes a raw 16-bit key map with a one-cycle scan_done pulse every full sweep.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 100
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic {ST_INIT, ST_SCAN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic             sample, publish;
  logic [3:0]       rows_nxt;
  logic [3:0]       col_meta, col_sync;
  logic [15:0]      scratch;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_INIT;
      counter <= '0;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      row_idx <= row_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    row_idx_nxt = row_idx;
    sample      = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt   = ST_SCAN;
        counter_nxt = '0;
        row_idx_nxt = '0;
      end
      ST_SCAN: begin
        if (counter == CNT_LAST) begin
          sample      = 1'b1;
          counter_nxt = '0;
          row_idx_nxt = row_idx + 2'd1;
        end else begin
          counter_nxt = counter + CNT_W'(1);
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Rows are registered from the next row index so the new row is driven right after the sample edge.
  always_comb begin
    rows_nxt = 4'b1111;
    if (state_nxt == ST_SCAN)
      rows_nxt = ~(4'b0001 << row_idx_nxt);
  end

  assign publish = sample && (row_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_meta        <= 4'b1111;
      col_sync        <= 4'b1111;
      scratch         <= '0;
      kp.rows         <= 4'b1111;
      kp.keys_pressed <= '0;
      kp.scan_done    <= 1'b0;
    end else begin
      col_meta     <= kp.cols;
      col_sync     <= col_meta;
      kp.rows      <= rows_nxt;
      kp.scan_done <= publish;
      if (sample)
        scratch[{row_idx, 2'b00} +: 4] <= ~col_sync;
      if (publish)
        kp.keys_pressed <= {~col_sync, scratch[11:0]};
    end
  end
endmodule
